// File: rtl/dbg_trace_buf_if.sv
// dbg_trace_buf_if: capture inputs, trigger setup and read port of the debug trace buffer. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

interface dbg_trace_buf_if #(
  parameter int DATA_W = 16,
  parameter int TS_W   = 16
);
  logic [DATA_W-1:0] dbg_in;
  logic              arm;
  logic [DATA_W-1:0] trig_val;
  logic [DATA_W-1:0] trig_mask;
  logic              rd_ack;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic [TS_W-1:0]   rd_ts;
  logic              armed;
  logic              done;
  logic              wrapped;

  modport master (
    output dbg_in, arm, trig_val, trig_mask, rd_ack,
    input  rd_valid, rd_data, rd_ts, armed, done, wrapped
  );

  modport slave (
    input  dbg_in, arm, trig_val, trig_mask, rd_ack,
    output rd_valid, rd_data, rd_ts, armed, done, wrapped
  );
endinterface

`default_nettype wire

// File: rtl/dbg_trace_buf.sv
// dbg_trace_buf: change-driven trace capture into a circular buffer, masked trigger, oldest-first drain.
// Optional per-entry timestamps when DBG_TRACE_TS_EN is defined. Rev 1.0
`timescale 1ns/1ps
`default_nettype none

module dbg_trace_buf #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8,
  parameter int POST   = 3,
  parameter int TS_W   = 16
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  dbg_trace_buf_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
`ifdef DBG_TRACE_TS_EN
  localparam int ENT_W = DATA_W + TS_W;
`else
  localparam int ENT_W = DATA_W;
`endif

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, TRIG = 2'd2, DONE = 2'd3} state_t;

  state_t            state, state_nxt;
  logic [ENT_W-1:0]  mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW-1:0]     post_left;
  logic [AW:0]       count;
  logic [DATA_W-1:0] last_val;
  logic              first_flag;
  logic              wrapped_q;
  logic              rd_valid_q;
  logic [ENT_W-1:0]  rd_entry;
  logic [ENT_W-1:0]  wr_entry;
  logic              capturing;
  logic              hit;
  logic              cap;
  logic              rd_pop;

  assign capturing = (state == ARMED) || (state == TRIG);
  assign hit       = (state == ARMED) && (((bus.dbg_in ^ bus.trig_val) & bus.trig_mask) == '0);
  assign cap       = capturing && ((bus.dbg_in != last_val) || first_flag || hit);
  assign rd_pop    = (state == DONE) && rd_valid_q && bus.rd_ack;
  // Oldest entry; count == DEPTH aliases to wr_ptr, which is correct once full.
  assign rd_ptr    = wr_ptr - count[AW-1:0];

`ifdef DBG_TRACE_TS_EN
  logic [TS_W-1:0] ts_cnt;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n)          ts_cnt <= '0;
    else if (bus.arm)   ts_cnt <= '0;
    else if (capturing) ts_cnt <= ts_cnt + 1'b1;
  end

  assign wr_entry  = {ts_cnt, bus.dbg_in};
  assign bus.rd_ts = rd_entry[ENT_W-1:DATA_W];
`else
  assign wr_entry  = bus.dbg_in;
  assign bus.rd_ts = {TS_W{1'b0}};
`endif

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    ;
      ARMED:   if (hit) state_nxt = (POST == 0) ? DONE : TRIG;
      TRIG:    if (cap && (post_left == AW'(1))) state_nxt = DONE;
      DONE:    if ((count == '0) || (rd_pop && (count == (AW+1)'(1)))) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (bus.arm) state_nxt = ARMED;
  end

  always_ff @(posedge clk) begin
    if (cap && !bus.arm) mem[wr_ptr] <= wr_entry;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_ptr     <= '0;
      count      <= '0;
      last_val   <= '0;
      first_flag <= 1'b0;
      post_left  <= '0;
      wrapped_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_entry   <= '0;
    end else if (bus.arm) begin
      wr_ptr     <= '0;
      count      <= '0;
      wrapped_q  <= 1'b0;
      first_flag <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      if (capturing) last_val <= bus.dbg_in;
      if (cap) begin
        wr_ptr     <= wr_ptr + 1'b1;
        first_flag <= 1'b0;
        if (count == (AW+1)'(DEPTH)) wrapped_q <= 1'b1;
        else                         count     <= count + 1'b1;
      end
      if (hit)                            post_left <= AW'(POST);
      else if (cap && (state == TRIG))    post_left <= post_left - 1'b1;
      // Popping drops rd_valid for one cycle while the next entry is fetched.
      if (state == DONE) begin
        if (rd_pop) begin
          count      <= count - 1'b1;
          rd_valid_q <= 1'b0;
        end else if (count != '0) begin
          rd_valid_q <= 1'b1;
          rd_entry   <= mem[rd_ptr];
        end else begin
          rd_valid_q <= 1'b0;
        end
      end else begin
        rd_valid_q <= 1'b0;
      end
    end
  end

  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data  = rd_entry[DATA_W-1:0];
  assign bus.armed    = capturing;
  assign bus.done     = (state == DONE);
  assign bus.wrapped  = wrapped_q;

endmodule

`default_nettype wire

// File: doc/dbg_trace_buf.md
Name: dbg_trace_buf

Overview:
- Parametrised trace capture for a CPU debug bus, e.g. the 16-bit dbg_out of the cpu16 cores.
- Records each change of dbg_in, with an optional timestamp, into a circular buffer.
- Stops a programmable number of entries after a masked-match trigger, then drains oldest-first through a ready/ack read port.
- Sits beside the CPU in benches and on-chip debug.

Parameters:
DATA_W, 16, width of traced debug word
DEPTH, 8, buffer entries; power of two, >= 4
POST, 3, entries captured after the trigger entry; 0 <= POST <= DEPTH-1
TS_W, 16, timestamp counter width

Ports:
clk  in  1  clock
rst_n  in  1  reset
dbg_in  in  DATA_W  traced debug word
arm  in  1  start or restart a capture
trig_val  in  DATA_W  trigger compare value
trig_mask  in  DATA_W  trigger mask; 1 = bit compared
rd_ack  in  1  pop current read entry
rd_valid  out  1  read entry available
rd_data  out  DATA_W  entry data
rd_ts  out  TS_W  entry timestamp
armed  out  1  state is ARMED or TRIG
done  out  1  state is DONE
wrapped  out  1  oldest entries were overwritten since arm

Behaviour:
- Interface: reset rst_n, asynchronous, active-high; clock clk.
- Reset values:
  - state IDLE, all pointers, counts, ts_cnt and last_val = 0.
  - rd_valid, armed, done, wrapped = 0; rd_data, rd_ts = 0.
- States:
  - IDLE: no capture. arm -> ARMED.
  - ARMED: capture entries. Trigger hit -> TRIG.
  - TRIG: capture entries; post_left decrements per entry after the trigger entry. post_left == 0 after an entry (or POST == 0) -> DONE.
  - DONE: no capture; readout. Count reaches 0 -> IDLE.
- arm in any state:
  - Next cycle: state ARMED, count = 0, wr_ptr = 0, ts_cnt = 0, wrapped = 0, first_flag = 1.
  - Highest priority over trigger, capture and rd_ack in the same cycle.
- ts_cnt increments every cycle in ARMED and TRIG and wraps modulo 2^TS_W. The cycle after arm has ts = 0.
- Capture condition, in ARMED or TRIG: (dbg_in != last_val) OR first_flag OR trigger-hit cycle.
  - last_val <= dbg_in every cycle in ARMED and TRIG.
  - first_flag clears after the first capture.
  - Entry written = {ts_cnt, dbg_in}.
- Trigger hit: state ARMED and ((dbg_in ^ trig_val) & trig_mask) == 0.
  - The hit cycle is always captured.
  - post_left <= POST.
  - Mask all-zero triggers on the first ARMED cycle.
  - No retrigger in TRIG.
- Buffer write: write at wr_ptr; wr_ptr increments modulo DEPTH.
  - count saturates at DEPTH.
  - Write when count == DEPTH overwrites the oldest entry and sets wrapped (sticky until arm).
- Readout (DONE only):
  - rd_valid = (count != 0).
  - rd_data/rd_ts = entry at rd_ptr, where rd_ptr = wr_ptr - count (mod DEPTH) is the oldest entry.
  - rd_ack with rd_valid: count decrements, and the next entry is presented the following cycle (registered outputs, 1-cycle latency; rd_valid low for that one cycle).
  - rd_ack without rd_valid is ignored.
- When count reaches 0 in DONE: state -> IDLE, done -> 0.
- rd_data/rd_ts hold their last value when rd_valid = 0.
- armed = (state == ARMED || state == TRIG); done = (state == DONE).
- Reset asserted mid-capture or mid-readout: immediate return to reset values; buffer contents don't care.

Optional Feature:
- Macro DBG_TRACE_TS_EN.
- Defined: timestamp counter implemented; entries are DATA_W+TS_W wide; rd_ts carries the capture timestamp.
- Undefined: no ts_cnt, entries are DATA_W wide, rd_ts tied to 0. All other behaviour identical.

Test Plan (DATA_W=16, DEPTH=8, POST=3, DBG_TRACE_TS_EN defined):
- Reset: rst_n=1 for 3 cycles, then 0 -> rd_valid=0, armed=0, done=0, wrapped=0, rd_data=0.
- Basic trace:
  - Stimulus: arm, mask=FFFF, trig_val=0x0005; dbg_in steps 0x0001..0x0008, one per cycle, first value on ts 0.
  - Required: trigger at 0x0005; done after 0x0008.
  - Readout 0x0001..0x0008 with ts 0..7, wrapped=0; then IDLE.
- Change filter:
  - Stimulus: dbg_in held 0x00AA for 10 cycles, then 0x00BB, 0x00BB, 0x0005 (trigger).
  - Required: entries 0x00AA(ts 0), 0x00BB(ts 10), 0x0005(ts 12), plus 3 post entries.
- Wrap:
  - Stimulus: 20 distinct values before the trigger.
  - Required: wrapped=1; readout yields exactly 8 entries: the last 4 pre-trigger, the trigger entry, then 3 post, oldest first.
- Masked trigger:
  - Stimulus: trig_mask=0x00F0, trig_val=0x0030.
  - Required: dbg_in 0x1234 fires; 0x1204 does not.
- Priority and reset:
  - arm asserted in DONE together with rd_ack -> next cycle armed=1, count=0, rd_valid=0.
  - Reset asserted during TRIG -> all outputs at reset values in the same cycle.
